// File: rtl/psum_column_accumulator.sv
// Accumulates the PE column's per-lane partial sums over cfg_acc_len beats and
// presents one TN-lane result per group through a single-entry valid/ready register.
module psum_column_accumulator #(
    parameter int TN     = 8,
    parameter int IN_DW  = 20,
    parameter int ACC_DW = 32,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     cfg_acc_len,
    input  logic [CNT_W-1:0]     cfg_grp_num,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [TN*IN_DW-1:0]  in_dat,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [TN*ACC_DW-1:0] out_dat,
    output logic                 busy,
    output logic                 done
);

    localparam int EXT_W = (ACC_DW > IN_DW) ? ACC_DW : IN_DW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  len_m1;
    logic [CNT_W-1:0]  grp_m1;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  grp_cnt;
    logic [ACC_DW-1:0] acc [TN];
    logic [ACC_DW-1:0] sum [TN];
    logic              last_beat;
    logic              beat_fire;

    // Sign-extend a lane to the accumulator width (truncating if ACC_DW < IN_DW).
    function automatic logic [ACC_DW-1:0] sext(input logic [IN_DW-1:0] v);
        logic signed [EXT_W-1:0] w;
        w = EXT_W'($signed(v));
        return w[ACC_DW-1:0];
    endfunction

    assign last_beat = (beat_cnt == len_m1);
    // Hold off the final beat while the previous result is still waiting downstream.
    assign in_rdy    = (state == S_ACC) && !(last_beat && out_vld && !out_rdy);
    assign beat_fire = in_vld && in_rdy;
    assign busy      = (state != S_IDLE);

    always_comb begin
        for (int n = 0; n < TN; n++) begin
            sum[n] = ((beat_cnt == '0) ? '0 : acc[n]) + sext(in_dat[n*IN_DW +: IN_DW]);
        end
    end

    // NOTE: sequential state uses <= only, so every register sees the pre-edge
    // values regardless of statement order; later assignments simply override.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            len_m1   <= '0;
            grp_m1   <= '0;
            beat_cnt <= '0;
            grp_cnt  <= '0;
            // NOTE: the accumulator array is reset explicitly so an aborted group
            // can never leak into the next run; this is small flop storage, not RAM.
            for (int n = 0; n < TN; n++) acc[n] <= '0;
            out_dat  <= '0;
            out_vld  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (out_rdy) out_vld <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_m1   <= (cfg_acc_len == '0) ? '0 : cfg_acc_len - CNT_W'(1);
                        grp_m1   <= (cfg_grp_num == '0) ? '0 : cfg_grp_num - CNT_W'(1);
                        beat_cnt <= '0;
                        grp_cnt  <= '0;
                        for (int n = 0; n < TN; n++) acc[n] <= '0;
                        state    <= S_ACC;
                    end
                end

                S_ACC: begin
                    if (beat_fire) begin
                        for (int n = 0; n < TN; n++) acc[n] <= sum[n];
                        if (last_beat) begin
                            for (int n = 0; n < TN; n++) out_dat[n*ACC_DW +: ACC_DW] <= sum[n];
                            out_vld  <= 1'b1;
                            beat_cnt <= '0;
                            grp_cnt  <= grp_cnt + CNT_W'(1);
                            if (grp_cnt == grp_m1) state <= S_DRAIN;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end

                S_DRAIN: begin
                    if (out_vld && out_rdy) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_column_accumulator.sv
// Directed bench for psum_column_accumulator: a TN=8/32-bit instance plus a
// single-lane 16-bit-accumulator instance sharing control, for wrap checks.
module tb_psum_column_accumulator;

    localparam int TN     = 8;
    localparam int IN_DW  = 20;
    localparam int ACC_DW = 32;
    localparam int CNT_W  = 16;
    localparam int CW     = TN * ACC_DW;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [CNT_W-1:0]     cfg_acc_len;
    logic [CNT_W-1:0]     cfg_grp_num;
    logic                 in_vld;
    logic                 in_rdy;
    logic [TN*IN_DW-1:0]  in_dat;
    logic                 out_vld;
    logic                 out_rdy;
    logic [CW-1:0]        out_dat;
    logic                 busy;
    logic                 done;

    logic                 in_rdy16;
    logic [IN_DW-1:0]     in_dat16;
    logic                 out_vld16;
    logic [15:0]          out_dat16;
    logic                 busy16;
    logic                 done16;

    int tests;
    int fails;

    psum_column_accumulator #(
        .TN(TN), .IN_DW(IN_DW), .ACC_DW(ACC_DW), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_acc_len(cfg_acc_len), .cfg_grp_num(cfg_grp_num),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat),
        .busy(busy), .done(done)
    );

    psum_column_accumulator #(
        .TN(1), .IN_DW(IN_DW), .ACC_DW(16), .CNT_W(CNT_W)
    ) u_dut16 (
        .clk(clk), .rst(rst), .start(start),
        .cfg_acc_len(cfg_acc_len), .cfg_grp_num(cfg_grp_num),
        .in_vld(in_vld), .in_rdy(in_rdy16), .in_dat(in_dat16),
        .out_vld(out_vld16), .out_rdy(out_rdy), .out_dat(out_dat16),
        .busy(busy16), .done(done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane n carries base + n*step.
    function automatic logic [TN*IN_DW-1:0] mk_dat(input int base, input int step);
        logic [TN*IN_DW-1:0] d;
        d = '0;
        for (int n = 0; n < TN; n++) d[n*IN_DW +: IN_DW] = IN_DW'(base + n * step);
        return d;
    endfunction

    function automatic logic [CW-1:0] mk_exp(input int base, input int step);
        logic [CW-1:0] e;
        e = '0;
        for (int n = 0; n < TN; n++) e[n*ACC_DW +: ACC_DW] = ACC_DW'(base + n * step);
        return e;
    endfunction

    task automatic kick(input int len, input int grp);
        cfg_acc_len = CNT_W'(len);
        cfg_grp_num = CNT_W'(grp);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [TN*IN_DW-1:0] d;
    logic [CW-1:0]       e;

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; start = 1'b0; cfg_acc_len = '0; cfg_grp_num = '0;
        in_vld = 1'b0; in_dat = '0; in_dat16 = '0; out_rdy = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_out_vld", CW'(out_vld), '0);
        check("rst_in_rdy",  CW'(in_rdy),  '0);
        check("rst_busy",    CW'(busy),    '0);
        check("rst_done",    CW'(done),    '0);
        check("rst_out_dat", out_dat,      '0);

        // Basic: len=4, grp=1, lane n gets n+1 each beat.
        kick(4, 1);
        check("basic_busy",   CW'(busy),   CW'(1));
        check("basic_in_rdy", CW'(in_rdy), CW'(1));
        in_vld = 1'b1; in_dat = mk_dat(1, 1);
        repeat (3) tick();
        check("basic_vld_early", CW'(out_vld), '0);
        tick();
        check("basic_vld",    CW'(out_vld), CW'(1));
        check("basic_dat",    out_dat,      mk_exp(4, 4));
        check("basic_done0",  CW'(done),    '0);
        check("basic_drain_rdy", CW'(in_rdy), '0);
        in_vld = 1'b0;
        tick();
        check("basic_done",   CW'(done),    CW'(1));
        check("basic_busy_lo", CW'(busy),   '0);
        check("basic_vld_lo", CW'(out_vld), '0);
        tick();
        check("basic_done_pulse", CW'(done), '0);

        // Signed and wrap: len=2.
        kick(2, 1);
        in_vld = 1'b1;
        d = '0;
        d[0 +: IN_DW]     = 20'hFFFFB;
        d[IN_DW +: IN_DW] = 20'h7FFFF;
        in_dat = d; in_dat16 = 20'h7FFFF;
        tick();
        d[0 +: IN_DW] = 20'hFFFF9;
        in_dat = d;
        tick();
        e = '0;
        e[0 +: ACC_DW]      = 32'hFFFF_FFF4;
        e[ACC_DW +: ACC_DW] = 32'h000F_FFFE;
        check("signed_dat", out_dat, e);
        check("wrap16_vld", CW'(out_vld16), CW'(1));
        check("wrap16_dat", CW'(out_dat16), CW'(16'hFFFE));
        in_vld = 1'b0; in_dat16 = '0;
        tick();
        check("signed_done", CW'(done), CW'(1));

        // Backpressure: len=1, grp=3, out_rdy low at first.
        out_rdy = 1'b0;
        kick(1, 3);
        in_vld = 1'b1; in_dat = mk_dat(1, 1);
        #1;
        check("bp_rdy_first", CW'(in_rdy), CW'(1));
        tick();
        check("bp_vld_g0", CW'(out_vld), CW'(1));
        check("bp_dat_g0", out_dat, mk_exp(1, 1));
        check("bp_stall",  CW'(in_rdy), '0);
        in_dat = mk_dat(101, 1);
        tick();
        check("bp_hold_vld", CW'(out_vld), CW'(1));
        check("bp_hold_dat", out_dat, mk_exp(1, 1));
        check("bp_hold_rdy", CW'(in_rdy), '0);
        out_rdy = 1'b1;
        #1;
        check("bp_release_rdy", CW'(in_rdy), CW'(1));
        tick();
        check("bp_vld_g1", CW'(out_vld), CW'(1));
        check("bp_dat_g1", out_dat, mk_exp(101, 1));
        in_dat = mk_dat(201, 1);
        tick();
        check("bp_dat_g2",   out_dat, mk_exp(201, 1));
        check("bp_busy_g2",  CW'(busy), CW'(1));
        check("bp_drain_rdy", CW'(in_rdy), '0);
        check("bp_done_early", CW'(done), '0);
        in_vld = 1'b0;
        tick();
        check("bp_done",   CW'(done), CW'(1));
        check("bp_vld_lo", CW'(out_vld), '0);

        // Zero config behaves as len=1, grp=1.
        kick(0, 0);
        in_vld = 1'b1; in_dat = mk_dat(-1, -1);
        tick();
        check("zero_vld", CW'(out_vld), CW'(1));
        check("zero_dat", out_dat, mk_exp(-1, -1));
        check("zero_rdy", CW'(in_rdy), '0);
        in_vld = 1'b0;
        tick();
        check("zero_done", CW'(done), CW'(1));

        // Start mid-group with a different config is ignored.
        kick(2, 1);
        in_vld = 1'b1; in_dat = mk_dat(3, 1);
        tick();
        cfg_acc_len = 16'd5; cfg_grp_num = 16'd4; start = 1'b1;
        in_dat = mk_dat(4, 2);
        tick();
        start = 1'b0;
        check("ign_vld", CW'(out_vld), CW'(1));
        check("ign_dat", out_dat, mk_exp(7, 3));
        check("ign_rdy", CW'(in_rdy), '0);
        in_vld = 1'b0;
        tick();
        check("ign_done", CW'(done), CW'(1));

        // Reset after 2 of 4 beats, then a clean run.
        kick(4, 1);
        in_vld = 1'b1; in_dat = mk_dat(50, 1);
        repeat (2) tick();
        rst = 1'b1; in_vld = 1'b0;
        tick();
        check("mid_rst_vld",  CW'(out_vld), '0);
        check("mid_rst_rdy",  CW'(in_rdy),  '0);
        check("mid_rst_busy", CW'(busy),    '0);
        check("mid_rst_done", CW'(done),    '0);
        check("mid_rst_dat",  out_dat,      '0);
        rst = 1'b0;
        kick(4, 1);
        in_vld = 1'b1; in_dat = mk_dat(1, 1);
        repeat (4) tick();
        check("clean_vld", CW'(out_vld), CW'(1));
        check("clean_dat", out_dat, mk_exp(4, 4));
        in_vld = 1'b0;
        tick();
        check("clean_done", CW'(done), CW'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/psum_column_accumulator.md
Name: psum_column_accumulator

Overview:
- Sits directly downstream of the systolic PE column.
- Consumes its per-lane partial sums (TN lanes, IN_DW signed bits each) and accumulates them over cfg_acc_len beats, one Tin slice per beat.
- Emits one accumulated TN-lane result per group through a single-entry valid/ready output register.
- Handles cfg_grp_num groups per run, then signals done.

Parameters:
TN, 8, number of output-channel lanes (matches column Tn)
IN_DW, 20, signed width of one lane of column output (log2Tin + 2*max data width)
ACC_DW, 32, signed accumulator width per lane; must be >= IN_DW
CNT_W, 16, width of beat and group counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; begins a run; honoured only in IDLE
cfg_acc_len  in  CNT_W  beats per group; sampled on accepted start; 0 treated as 1
cfg_grp_num  in  CNT_W  groups per run; sampled on accepted start; 0 treated as 1
in_vld  in  1  column output beat valid
in_rdy  out  1  block accepts beat this cycle
in_dat  in  TN*IN_DW  lane n at bits [n*IN_DW +: IN_DW], two's complement
out_vld  out  1  result register holds a valid group result
out_rdy  in  1  downstream accepts result
out_dat  out  TN*ACC_DW  lane n at bits [n*ACC_DW +: ACC_DW]
busy  out  1  high in ACC or DRAIN
done  out  1  one-cycle pulse when the last group's result is accepted

Behaviour:
- Reset (synchronous, any state, including mid-group): state=IDLE; accumulators, counters and out_dat=0; out_vld=0, in_rdy=0, busy=0, done=0.
- States:
  - IDLE: start -> latch cfg (0->1), clear beat_cnt, grp_cnt and accumulators -> ACC. start outside IDLE is ignored.
  - ACC: beat accepted when in_vld && in_rdy.
    - Each lane: acc = (beat_cnt==0 ? 0 : acc) + sign_extend(in_lane) to ACC_DW, wrapping mod 2^ACC_DW. No saturation.
    - On the accepted beat with beat_cnt==len-1: next cycle out_dat = final sums and out_vld=1; beat_cnt=0; grp_cnt++.
    - If that was group grp_num-1 -> DRAIN, else stay in ACC.
  - DRAIN: in_rdy=0. When out_vld && out_rdy -> IDLE, with done=1 for exactly that transition cycle.
- in_rdy:
  - Low outside ACC.
  - In ACC, also low while beat_cnt==len-1 && out_vld && !out_rdy, i.e. the prior result is not yet taken.
  - Otherwise high.
  - in_rdy is combinational from state, counters, out_vld and out_rdy.
  - No result is ever overwritten or dropped.
- Output register:
  - out_vld clears on the cycle out_rdy is high, unless a new final beat is accepted in the same cycle; then it stays 1 and out_dat takes the new result.
  - out_dat is stable while out_vld && !out_rdy.
- Latency: last beat accepted at cycle t -> out_vld=1 at t+1. With len=1, one beat per group; back-to-back groups sustain 1 result/cycle when out_rdy=1.
- in_vld without in_rdy is ignored; the upstream holds data.
- Accumulator for beats 1..len-1 is internal. out_dat changes only on group completion.
- busy = (state != IDLE).

Test Plan:
- Reset, TN=8, len=4, grp=1; lane n receives n+1 on every beat, in_vld=1, out_rdy=1 -> out_vld one cycle after 4th beat, lane n = 4*(n+1); done pulses the following cycle; busy falls with done.
- Signed/wrap: len=2, lane0 inputs -5 then -7 (IN_DW=20) -> lane0 = 0xFFFFFFF4. Lane1 inputs 0x7FFFF twice -> 0x000FFFFE. ACC_DW=16, lane0 inputs 0x7FFFF, 0x7FFFF -> 0xFFFE (wrap).
- Backpressure: len=1, grp=3, out_rdy=0 -> first result held, in_rdy low on the 2nd beat, out_dat unchanged. Raise out_rdy -> results arrive in order (group0, group1, group2), none lost; done after the 3rd is accepted.
- Zero cfg: cfg_acc_len=0, cfg_grp_num=0 -> behaves as len=1, grp=1; the single beat is passed through sign-extended.
- Start ignored: start pulse in ACC mid-group with different cfg -> no effect on counts or results.
- Reset mid-operation: rst=1 after 2 of 4 beats -> next cycle all outputs 0, state IDLE. New run with len=4 yields a clean sum with no carry-over from the aborted group.
